// File: rtl/dcache_miss_ctrl_if.sv
// ---------------------------------------------------------------------------
// dcache_miss_ctrl_if
//   TileLink-UL A/D channel bundle between the data-cache miss controller and
//   the memory-side slave. One outstanding transaction, no source/ID field.
//
//   A channel (master -> slave): a_valid, a_opcode, a_size, a_address,
//                                a_mask, a_data;  a_ready returns.
//   D channel (slave -> master): d_valid, d_opcode, d_denied, d_data;
//                                d_ready returns.
// ---------------------------------------------------------------------------
interface dcache_miss_ctrl_if;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_size;
    logic [63:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;

    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic        d_denied;
    logic [63:0] d_data;

    modport master (
        output a_valid, a_opcode, a_size, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_denied, d_data
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_denied, d_data
    );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_miss_ctrl
//   Sequencer for a direct-mapped, write-through data cache (32 lines x 64 b,
//   tag = addr[63:8], index = addr[7:3]). Load misses fetch the aligned
//   doubleword with a TL-UL Get and fill the line; stores go out as
//   PutFullData/PutPartialData and invalidate the line on the ack. The LSU is
//   stalled until each transaction retires.
//
//   Ports
//     clk, rst_n        core clock, asynchronous active-low reset
//     req_*             LSU request (held stable while stall = 1)
//     cache_hit         hit indication for cache_addr
//     stall             LSU must hold its request
//     err               one-cycle pulse: denied, protocol error or timeout
//     cache_addr        req_addr in IDLE, latched address otherwise
//     cache_update      cache update strobe; cache_opcode 1 = fill, 0 = inval
//     cache_data        fill data
//     tl                TL-UL A/D channels (master side)
// ---------------------------------------------------------------------------
module dcache_miss_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [63:0] req_addr,
    input  logic [7:0]  req_mask,
    input  logic [63:0] req_wdata,

    input  logic        cache_hit,
    output logic        stall,
    output logic        err,
    output logic [63:0] cache_addr,
    output logic        cache_update,
    output logic [2:0]  cache_opcode,
    output logic [63:0] cache_data,

    dcache_miss_ctrl_if.master tl
);

    localparam logic [2:0] A_GET         = 3'd4;
    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] D_ACK_DATA    = 3'd1;
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        A_REQ,
        WAIT_D,
        UPDATE,
        DONE
    } state_e;

    state_e            state_q,      state_d;
    logic [63:0]       addr_q,       addr_d;
    logic              store_q,      store_d;
    logic [7:0]        mask_q,       mask_d;
    logic [63:0]       wdata_q,      wdata_d;
    logic [2:0]        rsp_opcode_q, rsp_opcode_d;
    logic              rsp_denied_q, rsp_denied_d;
    logic [63:0]       rsp_data_q,   rsp_data_d;
    logic [TO_W-1:0]   cnt_q,        cnt_d;

    logic              fill_ok;

    // A load answered with good data fills; everything else invalidates.
    assign fill_ok = ~store_q & (rsp_opcode_q == D_ACK_DATA) & ~rsp_denied_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        store_d      = store_q;
        mask_d       = mask_q;
        wdata_d      = wdata_q;
        rsp_opcode_d = rsp_opcode_q;
        rsp_denied_d = rsp_denied_q;
        rsp_data_d   = rsp_data_q;
        cnt_d        = cnt_q;

        stall        = 1'b1;
        err          = 1'b0;
        cache_addr   = addr_q;
        cache_update = 1'b0;
        cache_opcode = 3'd0;
        cache_data   = 64'd0;

        tl.a_valid   = 1'b0;
        tl.a_opcode  = 3'd0;
        tl.a_size    = 3'd3;
        tl.a_address = 64'd0;
        tl.a_mask    = 8'd0;
        tl.a_data    = 64'd0;
        tl.d_ready   = 1'b0;

        unique case (state_q)
            IDLE: begin
                cache_addr = req_addr;
                // An op flagged as neither load nor store never stalls, so it
                // cannot wedge the LSU.
                stall = req_valid & (req_store | (req_load & ~cache_hit));
                if (req_valid && req_store) begin
                    addr_d  = req_addr;
                    store_d = 1'b1;
                    mask_d  = req_mask;
                    wdata_d = req_wdata;
                    state_d = A_REQ;
                end else if (req_valid && req_load && !cache_hit) begin
                    addr_d  = req_addr;
                    store_d = 1'b0;
                    state_d = A_REQ;
                end
            end

            A_REQ: begin
                // A fields come straight from registers, so they cannot move
                // while the slave back-pressures with a_ready = 0.
                tl.a_valid   = 1'b1;
                tl.a_opcode  = !store_q        ? A_GET      :
                               (mask_q == 8'hFF) ? A_PUT_FULL : A_PUT_PARTIAL;
                tl.a_address = {addr_q[63:3], 3'b000};
                tl.a_mask    = store_q ? mask_q : 8'hFF;
                tl.a_data    = wdata_q;
                if (tl.a_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT_D;
                end
            end

            WAIT_D: begin
                tl.d_ready = 1'b1;
                cnt_d      = cnt_q + TO_W'(1);
                // A response in the last counted cycle still wins.
                if (tl.d_valid) begin
                    rsp_opcode_d = tl.d_opcode;
                    rsp_denied_d = tl.d_denied;
                    rsp_data_d   = tl.d_data;
                    state_d      = UPDATE;
                end else if (cnt_q == CNT_LAST) begin
                    err     = 1'b1;
                    state_d = DONE;
                end
            end

            UPDATE: begin
                cache_update = 1'b1;
                cache_opcode = fill_ok ? 3'd1 : 3'd0;
                cache_data   = fill_ok ? rsp_data_q : 64'd0;
                err          = rsp_denied_q | (~store_q & (rsp_opcode_q != D_ACK_DATA));
                state_d      = DONE;
            end

            DONE: begin
                // Stall one more cycle so the load re-probes the filled line.
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its _d input regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            store_q      <= 1'b0;
            mask_q       <= '0;
            wdata_q      <= '0;
            rsp_opcode_q <= '0;
            rsp_denied_q <= 1'b0;
            rsp_data_q   <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            store_q      <= store_d;
            mask_q       <= mask_d;
            wdata_q      <= wdata_d;
            rsp_opcode_q <= rsp_opcode_d;
            rsp_denied_q <= rsp_denied_d;
            rsp_data_q   <= rsp_data_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule
